// File: rtl/vga_term_pkg.sv
// Shared constants and types for the 80x30 text terminal VRAM path.
package vga_term_pkg;

    localparam int unsigned TERM_COLS  = 80;
    localparam int unsigned TERM_ROWS  = 30;
    localparam int unsigned TERM_DEPTH = TERM_COLS * TERM_ROWS;
    localparam int unsigned VRAM_AW    = 12;
    localparam int unsigned VRAM_DW    = 8;

    localparam logic [VRAM_DW-1:0] FILL_CHAR = 8'h20;

    localparam logic [0:0] ARB_IDLE_ENC  = 1'b0;
    localparam logic [0:0] ARB_CLEAR_ENC = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE  = ARB_IDLE_ENC,
        ARB_CLEAR = ARB_CLEAR_ENC
    } arb_state_t;

endpackage

// File: rtl/vram_clear_seq.sv
// Clear-screen address sequencer: walks 0..DEPTH-1 one cell per free slot.
module vram_clear_seq
    import vga_term_pkg::*;
#(
    parameter int unsigned DEPTH = TERM_DEPTH,
    parameter int unsigned AW    = VRAM_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          active,
    input  logic          hold,
    output logic          step,
    output logic          done,
    output logic [AW-1:0] addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] cnt;

    // A fetch in the same cycle owns the port, so the sequence simply waits.
    assign step = active & ~hold & ~Reset;
    assign done = step & (cnt == LAST);
    assign addr = cnt;

    always_ff @(posedge Clk) begin
        if (Reset || start) begin
            cnt <= '0;
        end else if (step && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out fetch > clear > terminal writer.
// Hardware clear-screen is built only when VRAM_CLEAR_EN is defined.
module vram_arbiter
    import vga_term_pkg::*;
#(
    parameter int unsigned   DEPTH     = TERM_DEPTH,
    parameter int unsigned   AW        = VRAM_AW,
    parameter int unsigned   DW        = VRAM_DW,
    parameter logic [DW-1:0] FILL_CHAR = vga_term_pkg::FILL_CHAR
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_drop,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic          fetch_in_range;
    logic          fetch_hit;
    logic          wr_in_range;
    logic          wr_fire;
    logic          wr_hit;
    logic          clr_step;
    logic [AW-1:0] clr_addr;
    logic          f1_valid;
    logic          f1_oob;

    assign fetch_in_range = fetch_addr < DEPTH_A;
    assign fetch_hit      = ~Reset & fetch_req & fetch_in_range;
    assign wr_in_range    = wr_addr < DEPTH_A;
    assign wr_fire        = wr_valid & wr_ready;
    assign wr_hit         = wr_fire & wr_in_range;

`ifdef VRAM_CLEAR_EN
    arb_state_t state;
    logic       clr_start;
    logic       clr_done;

    assign clr_start = ~Reset & clr_req & (state == ARB_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE:  if (clr_req)  state <= ARB_CLEAR;
                ARB_CLEAR: if (clr_done) state <= ARB_IDLE;
                default:                 state <= ARB_IDLE;
            endcase
        end
    end

    vram_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (clr_start),
        .active (state == ARB_CLEAR),
        .hold   (fetch_req),
        .step   (clr_step),
        .done   (clr_done),
        .addr   (clr_addr)
    );

    assign clr_busy = (state == ARB_CLEAR);
    assign wr_ready = ~Reset & ~fetch_req & (state == ARB_IDLE) & ~clr_req;
`else
    logic unused_clr_req;

    assign unused_clr_req = clr_req;
    assign clr_step       = 1'b0;
    assign clr_addr       = '0;
    assign clr_busy       = 1'b0;
    assign wr_ready       = ~Reset & ~fetch_req;
`endif

    // Writer and clear are already blocked by fetch_req, so this order is only a tie-break.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (fetch_hit) begin
            ram_en   = 1'b1;
            ram_addr = fetch_addr;
        end else if (clr_step) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = FILL_CHAR;
        end else if (wr_hit) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            f1_valid    <= 1'b0;
            f1_oob      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            wr_drop     <= 1'b0;
        end else begin
            f1_valid    <= fetch_req;
            f1_oob      <= ~fetch_in_range;
            fetch_valid <= f1_valid;
            if (f1_valid) begin
                fetch_data <= f1_oob ? FILL_CHAR : ram_rdata;
            end
            wr_drop <= wr_fire & ~wr_in_range;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter; clear tests run when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;

    localparam int          DEPTH = 2400;
    localparam int          AW    = 12;
    localparam int          DW    = 8;
    localparam logic [7:0]  FILL  = 8'h20;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_drop;
    logic          clr_req;
    logic          clr_busy;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 Clk = ~Clk;

    vram_arbiter #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DW        (DW),
        .FILL_CHAR (8'h20)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_drop     (wr_drop),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous-read VRAM instance
    logic [7:0] vram [0:DEPTH-1] = '{default: 8'hA5};
    always @(posedge Clk) begin
        if (ram_en) begin
            if (ram_we) vram[ram_addr] <= ram_wdata;
            else        ram_rdata      <= vram[ram_addr];
        end
    end

    // Reference model state
    logic [7:0] model [0:DEPTH-1] = '{default: 8'hA5};
    bit  m_busy   = 1'b0;
    int  m_ptr    = 0;
    int  cyc      = 0;
    int  drop_due = -1;
    bit  last_acc = 1'b0;
    bit  mon_en   = 1'b0;
    int  total    = 0;
    int  bad      = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // One clock: check combinational outputs, apply the edge, update the model.
    task automatic tick();
        bit   rdy;
        bit   acc;
        bit   clr_w;
        bit   busy_pre;
        bit   in_rng;
        exp_t e;
        #1;
        busy_pre = m_busy;
        rdy   = !Reset && !fetch_req && !m_busy && !(CLR_EN && clr_req);
        acc   = wr_valid && rdy;
        clr_w = !Reset && m_busy && !fetch_req;
        chk("wr_ready", wr_ready, rdy);
        if (Reset) begin
            chk("ram_en_reset", ram_en, 0);
        end else if (fetch_req) begin
            in_rng = int'(fetch_addr) < DEPTH;
            if (in_rng) begin
                chk("fetch_ram_en", ram_en, 1);
                chk("fetch_ram_we", ram_we, 0);
                chk("fetch_ram_addr", ram_addr, fetch_addr);
            end else begin
                chk("fetch_oob_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
            end
            e.due  = cyc + 2;
            e.data = in_rng ? model[fetch_addr] : FILL;
            exp_q.push_back(e);
        end else if (clr_w) begin
            chk("clr_ram_en", ram_en, 1);
            chk("clr_ram_we", ram_we, 1);
            chk("clr_ram_addr", ram_addr, m_ptr);
            chk("clr_ram_wdata", ram_wdata, FILL);
        end else if (acc && int'(wr_addr) < DEPTH) begin
            chk("wr_ram_en", ram_en, 1);
            chk("wr_ram_we", ram_we, 1);
            chk("wr_ram_addr", ram_addr, wr_addr);
            chk("wr_ram_wdata", ram_wdata, wr_data);
        end else begin
            chk("ram_idle", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
        end
        @(posedge Clk);
        cyc++;
        last_acc = acc;
        if (Reset) begin
            m_busy   = 1'b0;
            m_ptr    = 0;
            drop_due = -1;
            exp_q.delete();
        end else begin
            if (acc) begin
                if (int'(wr_addr) < DEPTH) model[wr_addr] = wr_data;
                else                       drop_due = cyc;
            end
            if (clr_w) begin
                model[m_ptr] = FILL;
                m_ptr++;
                if (m_ptr == DEPTH) m_busy = 1'b0;
            end
            if (!busy_pre && CLR_EN && clr_req) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
        end
        @(negedge Clk);
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = d;
        last_acc = 1'b0;
        while (!last_acc && n < 5000) begin
            tick();
            clr_req = 1'b0;
            n++;
        end
        if (!last_acc) chk("wr_accept_timeout", wr_ready, 1);
        wr_valid = 1'b0;
    endtask

    task automatic do_fetch(input int a);
        fetch_req  = 1'b1;
        fetch_addr = AW'(a);
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (m_busy && n < 5000) begin
            tick();
            n++;
        end
        chk("clr_busy_settled", clr_busy, 0);
    endtask

    // Monitor: pops the scoreboard when a response is due and compares
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    chk("fetch_valid", fetch_valid, 1);
                    chk("fetch_data", fetch_data, e.data);
                end else begin
                    chk("fetch_valid_idle", fetch_valid, 0);
                end
                chk("wr_drop", wr_drop, drop_due == cyc);
                chk("clr_busy", clr_busy, m_busy);
            end
        end
    end

    initial begin
        int n;
        int nf;
        Reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        clr_req    = 1'b0;
        @(negedge Clk);
        repeat (3) tick();
        Reset = 1'b0;
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_clr_busy", clr_busy, 0);
        mon_en = 1'b1;

        // Basic write then fetch
        do_write(5, 8'h41);
        do_fetch(5);
        repeat (3) tick();

        // Writer stalled by three fetch cycles, accepted on the fourth
        wr_valid = 1'b1;
        wr_addr  = 12'd100;
        wr_data  = 8'h42;
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'($urandom_range(0, 99));
            tick();
            chk("wr_stalled", wr_ready, 0);
        end
        fetch_req = 1'b0;
        tick();
        wr_valid = 1'b0;
        do_fetch(100);
        do_fetch(4095);
        do_fetch(2400);
        repeat (3) tick();

        // Out-of-range write is dropped
        do_write(2400, 8'h99);
        repeat (3) tick();

        // Clear request together with a write: clear wins when enabled, ignored otherwise
        clr_req = 1'b1;
        do_write(7, 8'h3C);
        wait_clear();
        do_fetch(7);
        do_fetch(8);
        repeat (3) tick();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            fetch_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) fetch_addr = AW'($urandom_range(2400, 4095));
            else                           fetch_addr = AW'($urandom_range(0, 63));
            if (!wr_valid && $urandom_range(0, 1) == 1) begin
                wr_valid = 1'b1;
                if ($urandom_range(0, 15) == 0) wr_addr = AW'($urandom_range(2400, 4095));
                else                            wr_addr = AW'($urandom_range(0, 63));
                wr_data = 8'($urandom);
            end
            clr_req = ($urandom_range(0, 399) == 0);
            tick();
            if (last_acc) wr_valid = 1'b0;
            clr_req = 1'b0;
        end
        fetch_req = 1'b0;
        wr_valid  = 1'b0;
        wait_clear();
        repeat (3) tick();

`ifdef VRAM_CLEAR_EN
        // Full clear with no fetches while a write waits
        clr_req  = 1'b1;
        tick();
        clr_req  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 12'd7;
        wr_data  = 8'h3C;
        n = 0;
        while (clr_busy && n < 3000) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, 2400);
        do_write(7, 8'h3C);
        do_fetch(0);
        do_fetch(1);
        do_fetch(1234);
        do_fetch(2399);
        do_fetch($urandom_range(8, 2399));
        repeat (3) tick();

        // Clear interleaved with a fetch every 8th cycle
        for (int i = 0; i < 10; i++) do_write(i, 8'(8'h60 + i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n  = 0;
        nf = 0;
        while (clr_busy && n < 4000) begin
            fetch_req  = (n % 8 == 7);
            fetch_addr = AW'($urandom_range(0, 2399));
            if (fetch_req) nf++;
            tick();
            n++;
        end
        fetch_req = 1'b0;
        chk("clear_cycles_with_fetch", n, 2400 + nf);
        repeat (3) tick();

        // Reset after 50 clear writes
        do_write(50, 8'h77);
        do_write(10, 8'h66);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (m_ptr < 50 && n < 200) begin
            tick();
            n++;
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("clr_busy_after_reset", clr_busy, 0);
        do_fetch(10);
        do_fetch(49);
        do_fetch(50);
        do_fetch(51);
        repeat (3) tick();
`endif

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
